display_scan_ctrl: RTL

Time-multiplexed 4-digit scan controller that sits directly upstream of the 2-to-4 one-hot digit decoder. It divides the system clock into a scan tick and steps a 2-bit digit index whose bits drive the decoder's `a`/`b` select inputs. It presents the nibble and blank flag for the currently selected digit. A new 16-bit display word is double-buffered so that it only takes effect at a frame boundary, which prevents tearing mid-scan.

---
 rtl/display_scan_ctrl.sv | 58 +++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit scan controller with prescaler, digit index and frame-synchronous double buffer
module display_scan_ctrl #(
    parameter int DIV = 4,
    parameter int CW  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  blank_in,
    output logic        busy,
    output logic        sel_a,
    output logic        sel_b,
    output logic [3:0]  digit_val,
    output logic        digit_blank,
    output logic        frame_done
);
    logic [CW-1:0] pc;
    logic [1:0]    idx;
    logic [15:0]   act, pnd;
    logic [3:0]    actb, pndb;
    logic          tick, wrap;
    assign tick = en && (pc == CW'(DIV - 1));
    assign wrap = tick && (idx == 2'd3);
    // prescaler and digit index advance only while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= '0;
            idx <= '0;
        end else begin
            pc  <= tick ? '0 : en ? pc + 1'b1 : pc;
            idx <= tick ? idx + 2'd1 : idx;
        end
    end
    // pending word is captured on load and promoted to active only at the frame wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pnd        <= '0;
            pndb       <= '0;
            act        <= '0;
            actb       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pnd        <= load ? din : pnd;
            pndb       <= load ? blank_in : pndb;
            act        <= (wrap && busy) ? pnd : act;
            actb       <= (wrap && busy) ? pndb : actb;
            busy       <= load || (busy && !wrap);
            frame_done <= wrap;
        end
    end
    assign sel_a       = idx[1];
    assign sel_b       = idx[0];
    assign digit_val   = act[{idx, 2'b00} +: 4];
    assign digit_blank = actb[idx];
endmodule
